// File: rtl/multi_cycle_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the gt/eq/lt result word.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} cmp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

  localparam cmp_result_t CMP_RESULT_RESET = '0;

endpackage

// File: rtl/multi_cycle_comparator_slice_cmp.sv
// Combinational SLICE-bit magnitude compare, MSB-first priority on the first differing bit.
// invert_msb flips the top bit of both inputs so the sign slice orders as two's complement.
module slice_cmp #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             invert_msb,
  output logic             gt,
  output logic             lt
);

  logic [SLICE-1:0] flip;
  logic [SLICE-1:0] a_x;
  logic [SLICE-1:0] b_x;

  assign flip = SLICE'(invert_msb) << (SLICE - 1);
  assign a_x  = a ^ flip;
  assign b_x  = b ^ flip;

  // Priority scan instead of a relational operator keeps the compare free of carry chains.
  always_comb begin
    logic found;
    gt    = 1'b0;
    lt    = 1'b0;
    found = 1'b0;
    for (int i = SLICE - 1; i >= 0; i--) begin
      if (!found && (a_x[i] != b_x[i])) begin
        gt    = a_x[i];
        lt    = b_x[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_cycle_comparator.sv
// Sequential WIDTH-bit magnitude comparator, SLICE bits per cycle MSB-first with early exit.
// Optional signed ordering via signed_mode when MULTI_CYCLE_COMPARATOR_SIGNED_EN is defined.
module multi_cycle_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
`ifdef MULTI_CYCLE_COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NS = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int CW = $clog2(NS) + 1;

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_param_check
    $error("multi_cycle_comparator: WIDTH must be a non-zero multiple of SLICE");
  end

  cmp_state_t  state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    k_q, k_d;
  cmp_result_t res_q, res_d;
  logic             invert_msb;
  logic             slice_gt;
  logic             slice_lt;

`ifdef MULTI_CYCLE_COMPARATOR_SIGNED_EN
  logic signed_q, signed_d;
  assign invert_msb = signed_q && (k_q == '0);
`else
  assign invert_msb = 1'b0;
`endif

  slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
    .a          (a_q[WIDTH-1 -: SLICE]),
    .b          (b_q[WIDTH-1 -: SLICE]),
    .invert_msb (invert_msb),
    .gt         (slice_gt),
    .lt         (slice_lt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
`ifdef MULTI_CYCLE_COMPARATOR_SIGNED_EN
    signed_d = signed_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = num1;
          b_d     = num2;
          k_d     = '0;
`ifdef MULTI_CYCLE_COMPARATOR_SIGNED_EN
          signed_d = signed_mode;
`endif
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (slice_gt || slice_lt) begin
          res_d   = '{gt: slice_gt, eq: 1'b0, lt: slice_lt};
          state_d = DONE;
        end else if (k_q == CW'(NS - 1)) begin
          res_d   = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
          state_d = DONE;
        end else begin
          a_d = a_q << SLICE;
          b_d = b_q << SLICE;
          k_d = k_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= CMP_RESULT_RESET;
`ifdef MULTI_CYCLE_COMPARATOR_SIGNED_EN
      signed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
`ifdef MULTI_CYCLE_COMPARATOR_SIGNED_EN
      signed_q <= signed_d;
`endif
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == COMPARE);
  assign done  = (state_q == DONE);
  assign gt    = res_q.gt;
  assign eq    = res_q.eq;
  assign lt    = res_q.lt;

endmodule
